pokey_audio_decim: RTL and testbench
====================================

# pokey_audio_decim

Downstream audio back-end for the POKEY sound cores. Each POKEY instance delivers an 8-bit unsigned `audout` sum at `clk_i` rate, and this block samples `NUM_CH` of those buses every clock. It box-car averages them over a fixed window of `DECIM` clocks and converts the result to 16-bit two's-complement PCM. The samples go to the codec/serializer stage through a valid/ready handshake, with overrun detection and mute.

## Interface
Parameters:
- `NUM_CH`, default 3: number of POKEY `audout` buses mixed; legal range 1..4.
- `DECIM`, default 32: clocks per output sample; power of two, 2..256.
- `DLOG`, default 5: log2(`DECIM`); must match `DECIM`.

Ports:
- `clk_i`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `audin`  in  8*`NUM_CH`: channel k at bits [8k+7:8k]; unsigned.
- `ch_en`  in  `NUM_CH`: per-channel enable; a disabled channel contributes 0.
- `mute`  in  1: forces emitted samples to 16'h0000.
- `pcm_data`  out  16: signed PCM sample.
- `pcm_valid`  out  1: `pcm_data` holds an unaccepted sample.
- `pcm_ready`  in  1: consumer accepts when `pcm_valid` and `pcm_ready` are both high at a rising edge.
- `tick`  out  1: one-cycle pulse, the cycle after each window closes.
- `overrun`  out  1: sticky; a sample was dropped.
- `clr_ovr`  in  1: clears `overrun`.

## Operation
- Per-clock sum: S = Σ (`ch_en`[k] ? `audin`[k] : 0), 10 bits wide. This is exact for up to 4×255.
- Window counter `phase` runs 0..`DECIM`-1 and wraps to 0.
- Accumulator `acc` is (10+`DLOG`) bits.
  - At `phase` = 0: `acc` <= S.
  - Otherwise: `acc` <= `acc` + S.
- Window close at `phase` = `DECIM`-1:
  - total T = `acc` + S.
  - avg = T >> `DLOG` (10 bits; truncation, no rounding).
  - sample = ({avg, 6'b0}) ^ 16'h8000, i.e. offset-binary to two's complement. avg 0 maps to −32768.
  - If `mute` is sampled high in that cycle, sample = 16'h0000.
- Output register, evaluated at window close:
  - If `pcm_valid` = 0, or the handshake completes in the same cycle: `pcm_data` <= sample and `pcm_valid` <= 1.
  - Otherwise the new sample is dropped, `pcm_data` is unchanged, and `overrun` <= 1.
- Handshake:
  - A handshake with no concurrent window close clears `pcm_valid` on the next edge.
  - `pcm_data` is stable while `pcm_valid` = 1 and no handshake has occurred.
- `overrun`:
  - Set as above.
  - `clr_ovr` clears it.
  - If set and clear happen in the same cycle, set wins.
- `tick` is registered: high for the one cycle after every window-close edge, whether the sample was stored or dropped.
- Input changes mid-window are averaged in. There is no filtering beyond the box-car.

## Timing
- Reset values: `phase` = 0, `acc` = 0, `pcm_data` = 16'h0000, `pcm_valid` = 0, `tick` = 0, `overrun` = 0.
- Window timing:
  - The first cycle after `rst` deasserts is `phase` 0.
  - The window covers cycles 0..`DECIM`-1.
  - `pcm_valid` and `tick` are first high in cycle `DECIM`, i.e. one clock of latency after the last contributing input.
- Throughput is one sample per `DECIM` clocks. A consumer asserting `pcm_ready` within `DECIM`-1 cycles of `pcm_valid` never causes an overrun.
- `audin`, `ch_en` and `mute` are consumed combinationally into the sum on the same edge. The source must register them; POKEY `audout` is combinational from registered state, so this holds.
- `rst` mid-window discards the partial window and any pending sample. The window restarts at `phase` 0 after release.

## Test plan
- Constant window: `NUM_CH`=3, `DECIM`=32, `audin` = 10/20/30, all enabled. Expect S=60, T=1920, avg=60, `pcm_data`=16'h8F00, with `pcm_valid` rising in cycle 32 after reset release; `tick` pulses every 32 cycles.
- Full scale and zero:
  - All channels 255: expect 16'h3F40.
  - All channels 0: expect 16'h8000.
  - `ch_en`=3'b010 with 10/20/30: expect avg 20, 16'h8500.
- Mid-window change: channel 0 = 0 for 16 cycles, then 64 for 16 cycles, others 0. Expect avg 32, 16'h8800.
- Backpressure:
  - Hold `pcm_ready`=0 across two windows: expect the first sample retained, `overrun`=1 after the second close.
  - Pulse `clr_ovr`: expect `overrun`=0.
  - Assert `pcm_ready` exactly on a close cycle: expect the new sample loaded, no overrun.
- `mute` asserted at a window close: expect 16'h0000. Asserted only at mid-window: expect a normal sample.
- Reset mid-window at `phase` 17 with `pcm_valid`=1: expect all outputs to return to reset values next cycle; the first post-reset sample reflects only post-reset inputs, 32 cycles later.

Source files
------------

// File: rtl/pokey_audio_decim_if.sv
// PCM sample handshake between the POKEY decimator and the codec/serializer stage.
// The producer drives data/valid, the consumer drives ready.
interface pokey_audio_decim_if;
   logic signed [15:0] pcm_data;
   logic               pcm_valid;
   logic               pcm_ready;

   modport master (output pcm_data, output pcm_valid, input pcm_ready);
   modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pokey_audio_decim.sv
// Box-car decimator: averages NUM_CH unsigned POKEY audout buses over DECIM clocks
// and emits 16-bit two's-complement PCM through a valid/ready handshake.
module pokey_audio_decim #(
   parameter int NUM_CH = 3,
   parameter int DECIM  = 32,
   parameter int DLOG   = 5
) (
   input  logic                  clk_i,
   input  logic                  rst,
   input  logic [8*NUM_CH-1:0]   audin,
   input  logic [NUM_CH-1:0]     ch_en,
   input  logic                  mute,
   output logic                  tick,
   output logic                  overrun,
   input  logic                  clr_ovr,
   pokey_audio_decim_if.master   pcm
);

   localparam int ACC_W = 10 + DLOG;

   // Offset-binary average to two's complement; mute overrides the sample.
   function automatic logic signed [15:0] to_pcm(input logic [ACC_W-1:0] total,
                                                 input logic             mute_in);
      logic [9:0] avg;
      avg = total[DLOG+9:DLOG];
      if (mute_in)
         return 16'sh0000;
      return $signed({avg, 6'b0} ^ 16'h8000);
   endfunction

   logic [9:0]              w_sum;
   logic [ACC_W-1:0]        w_total;
   logic                    w_close;
   logic                    w_hs;
   logic [DLOG-1:0]         r_phase;
   logic [ACC_W-1:0]        r_acc;
   logic signed [15:0]      r_pcm_data;
   logic                    r_pcm_valid;
   logic                    r_tick;
   logic                    r_overrun;

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_en[k])
            w_sum = w_sum + {2'b00, audin[8*k +: 8]};
      end
   end

   assign w_total = r_acc + {{DLOG{1'b0}}, w_sum};
   assign w_close = (r_phase == DLOG'(DECIM - 1));
   assign w_hs    = r_pcm_valid & pcm.pcm_ready;

   // Stage p0: window accumulation; the phase counter wraps naturally at DECIM.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_phase <= '0;
         r_acc   <= '0;
      end else begin
         r_phase <= r_phase + 1'b1;
         if (r_phase == '0)
            r_acc <= {{DLOG{1'b0}}, w_sum};
         else
            r_acc <= w_total;
      end
   end

   // Stage p1: output register with overrun detection on a blocked close.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_pcm_data  <= '0;
         r_pcm_valid <= 1'b0;
         r_tick      <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_tick <= w_close;
         if (w_close) begin
            if (!r_pcm_valid || w_hs) begin
               r_pcm_data  <= to_pcm(w_total, mute);
               r_pcm_valid <= 1'b1;
            end
         end else if (w_hs) begin
            r_pcm_valid <= 1'b0;
         end
         if (w_close && r_pcm_valid && !w_hs)
            r_overrun <= 1'b1;
         else if (clr_ovr)
            r_overrun <= 1'b0;
      end
   end

   assign pcm.pcm_data  = r_pcm_data;
   assign pcm.pcm_valid = r_pcm_valid;
   assign tick          = r_tick;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_pokey_audio_decim.sv
// Directed bench for pokey_audio_decim (NUM_CH=3, DECIM=32) with hand-computed PCM values.
module tb_pokey_audio_decim;

   logic        clk_i = 1'b0;
   logic        rst;
   logic [23:0] audin;
   logic [2:0]  ch_en;
   logic        mute;
   logic        tick;
   logic        overrun;
   logic        clr_ovr;
   int          nchk  = 0;
   int          npass = 0;
   int          nfail = 0;

   pokey_audio_decim_if pcm_if ();

   pokey_audio_decim #(.NUM_CH(3), .DECIM(32), .DLOG(5)) dut (
      .clk_i   (clk_i),
      .rst     (rst),
      .audin   (audin),
      .ch_en   (ch_en),
      .mute    (mute),
      .tick    (tick),
      .overrun (overrun),
      .clr_ovr (clr_ovr),
      .pcm     (pcm_if.master)
   );

   always #5 clk_i = ~clk_i;

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
      audin = {a2, a1, a0};
   endtask

   initial begin
      rst = 1'b1; mute = 1'b0; clr_ovr = 1'b0; ch_en = 3'b111;
      pcm_if.pcm_ready = 1'b0;
      set_ch(8'd10, 8'd20, 8'd30);
      step(3);
      chk("rst_data",    pcm_if.pcm_data, 16'h0000);
      chk("rst_valid",   16'(pcm_if.pcm_valid), 16'h0);
      chk("rst_tick",    16'(tick), 16'h0);
      chk("rst_overrun", 16'(overrun), 16'h0);

      // Window 1: constant 10/20/30 -> avg 60.
      @(negedge clk_i); rst = 1'b0;
      step(31);
      chk("w1_valid_early", 16'(pcm_if.pcm_valid), 16'h0);
      chk("w1_tick_early",  16'(tick), 16'h0);
      step(1);
      chk("w1_valid", 16'(pcm_if.pcm_valid), 16'h1);
      chk("w1_data",  pcm_if.pcm_data, 16'h8F00);
      chk("w1_tick",  16'(tick), 16'h1);

      // Window 2: full scale with consumer always ready.
      pcm_if.pcm_ready = 1'b1;
      set_ch(8'd255, 8'd255, 8'd255);
      step(1);
      chk("w2_tick_low",   16'(tick), 16'h0);
      chk("w2_valid_clr",  16'(pcm_if.pcm_valid), 16'h0);
      step(31);
      chk("w2_data",  pcm_if.pcm_data, 16'h3F40);
      chk("w2_tick",  16'(tick), 16'h1);

      // Window 3: all zero.
      set_ch(8'd0, 8'd0, 8'd0);
      step(32);
      chk("w3_data", pcm_if.pcm_data, 16'h8000);

      // Window 4: only channel 1 enabled -> avg 20.
      set_ch(8'd10, 8'd20, 8'd30); ch_en = 3'b010;
      step(32);
      chk("w4_data", pcm_if.pcm_data, 16'h8500);

      // Window 5: channel 0 steps 0 -> 64 half way -> avg 32.
      ch_en = 3'b111; set_ch(8'd0, 8'd0, 8'd0);
      step(16);
      set_ch(8'd64, 8'd0, 8'd0);
      step(16);
      chk("w5_data", pcm_if.pcm_data, 16'h8800);

      // Window 6: mute only on the closing cycle.
      set_ch(8'd10, 8'd20, 8'd30);
      step(31);
      mute = 1'b1;
      step(1);
      mute = 1'b0;
      chk("w6_mute_data",  pcm_if.pcm_data, 16'h0000);
      chk("w6_mute_valid", 16'(pcm_if.pcm_valid), 16'h1);

      // Window 7: mute only mid-window.
      step(16);
      mute = 1'b1;
      step(1);
      mute = 1'b0;
      step(15);
      chk("w7_data", pcm_if.pcm_data, 16'h8F00);

      // Window 8: drain the w7 sample, then stall; full-scale sample is loaded.
      set_ch(8'd255, 8'd255, 8'd255);
      step(1);
      pcm_if.pcm_ready = 1'b0;
      step(31);
      chk("w8_data",    pcm_if.pcm_data, 16'h3F40);
      chk("w8_overrun", 16'(overrun), 16'h0);

      // Window 9: still stalled; zero sample dropped, first retained.
      set_ch(8'd0, 8'd0, 8'd0);
      step(32);
      chk("w9_data_kept", pcm_if.pcm_data, 16'h3F40);
      chk("w9_valid",     16'(pcm_if.pcm_valid), 16'h1);
      chk("w9_overrun",   16'(overrun), 16'h1);
      chk("w9_tick",      16'(tick), 16'h1);

      // Window 10: clear overrun, then accept exactly on the close cycle.
      clr_ovr = 1'b1;
      step(1);
      clr_ovr = 1'b0;
      chk("clr_overrun", 16'(overrun), 16'h0);
      step(30);
      pcm_if.pcm_ready = 1'b1;
      step(1);
      pcm_if.pcm_ready = 1'b0;
      chk("w10_data",    pcm_if.pcm_data, 16'h8000);
      chk("w10_valid",   16'(pcm_if.pcm_valid), 16'h1);
      chk("w10_overrun", 16'(overrun), 16'h0);

      // Window 11: reset at phase 17 with a pending sample.
      set_ch(8'd255, 8'd255, 8'd255);
      step(17);
      rst = 1'b1;
      step(1);
      chk("mid_rst_data",    pcm_if.pcm_data, 16'h0000);
      chk("mid_rst_valid",   16'(pcm_if.pcm_valid), 16'h0);
      chk("mid_rst_tick",    16'(tick), 16'h0);
      chk("mid_rst_overrun", 16'(overrun), 16'h0);
      rst = 1'b0;
      set_ch(8'd10, 8'd20, 8'd30);
      step(31);
      chk("post_rst_valid_early", 16'(pcm_if.pcm_valid), 16'h0);
      step(1);
      chk("post_rst_data",  pcm_if.pcm_data, 16'h8F00);
      chk("post_rst_valid", 16'(pcm_if.pcm_valid), 16'h1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
